// File: rtl/pc_redirect_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : pc_redirect_unit                                             |
// | Description : Fetch PC sequencer with redirect acceptance and flush bubbles|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iTransf,
  input  logic [31:0] iTargetPC,
  input  logic        iStall,
  input  logic        iFetchAck,
  output logic        oFetchReq,
  output logic [31:0] oFetchAddr,
  output logic [31:0] oPC,
  output logic        oInstrValid,
  output logic        oFlush,
  output logic        oMisalign,
  output logic [15:0] oRedirCnt
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;
  localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [1:0]  r_state;
  logic [1:0]  w_nextState;
  logic [31:0] r_pc;
  logic [2:0]  r_bubbleCnt;
  logic        r_instrValid;
  logic        r_misalign;
  logic [15:0] r_redirCnt;

  logic w_active;
  logic w_aligned;
  logic w_redirect;
  logic w_badTarget;
  logic w_advance;

  // Transfers are only honoured once the fetch engine is running
  assign w_active    = (r_state == c_FETCH) || (r_state == c_FLUSH);
  assign w_aligned   = (iTargetPC[1:0] == 2'b00);
  assign w_redirect  = iTransf & w_aligned & w_active;
  assign w_badTarget = iTransf & ~w_aligned & w_active;
  assign w_advance   = (r_state == c_FETCH) & ~w_redirect & ~iStall & iFetchAck;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  w_nextState = c_FETCH;
      c_FETCH: if (w_redirect) w_nextState = c_FLUSH;
      c_FLUSH: begin
        if (w_redirect) begin
          w_nextState = c_FLUSH;
        end else if (r_bubbleCnt <= 3'd1) begin
          w_nextState = c_FETCH;
        end
      end
      default: w_nextState = c_IDLE;
    endcase
  end

  always_comb begin
    oFetchReq = (r_state == c_FETCH);
    oFlush    = (r_state == c_FLUSH);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_pc         <= RESET_PC;
      r_bubbleCnt  <= 3'd0;
      r_instrValid <= 1'b0;
      r_misalign   <= 1'b0;
      r_redirCnt   <= 16'd0;
    end else begin
      r_instrValid <= w_advance;
      if (w_redirect) begin
        r_pc        <= iTargetPC;
        r_bubbleCnt <= c_FLUSH_LOAD;
        if (r_redirCnt != 16'hFFFF) begin
          r_redirCnt <= r_redirCnt + 16'd1;
        end
      end else if (r_state == c_FLUSH) begin
        r_bubbleCnt <= r_bubbleCnt - 3'd1;
      end
      if (w_advance) begin
        r_pc <= r_pc + 32'd4;
      end
      // Misaligned targets leave PC and flow untouched; only the flag records them
      if (w_badTarget) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign oPC         = r_pc;
  assign oFetchAddr  = r_pc;
  assign oInstrValid = r_instrValid;
  assign oMisalign   = r_misalign;
  assign oRedirCnt   = r_redirCnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_redirect_unit                                          |
// | Description : Directed plus random bench for pc_redirect_unit, two configs |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_redirect_unit;

  logic        clk;
  logic        rst;
  logic        transf;
  logic [31:0] targetPC;
  logic        stall;
  logic        fetchAck;

  logic [1:0]        fetchReq;
  logic [1:0][31:0]  fetchAddr;
  logic [1:0][31:0]  pcOut;
  logic [1:0]        instrValid;
  logic [1:0]        flush;
  logic [1:0]        misalign;
  logic [1:0][15:0]  redirCnt;

  int nChecks = 0;
  int nErrors = 0;

  // Instance 0: default config; instance 1: wrapping reset PC and longer flush
  pc_redirect_unit #(.RESET_PC(32'h0040_0000), .FLUSH_CYCLES(2)) dut0 (
    .iCLK(clk), .iRST(rst), .iTransf(transf), .iTargetPC(targetPC),
    .iStall(stall), .iFetchAck(fetchAck),
    .oFetchReq(fetchReq[0]), .oFetchAddr(fetchAddr[0]), .oPC(pcOut[0]),
    .oInstrValid(instrValid[0]), .oFlush(flush[0]), .oMisalign(misalign[0]),
    .oRedirCnt(redirCnt[0])
  );

  pc_redirect_unit #(.RESET_PC(32'hFFFF_FFFC), .FLUSH_CYCLES(3)) dut1 (
    .iCLK(clk), .iRST(rst), .iTransf(transf), .iTargetPC(targetPC),
    .iStall(stall), .iFetchAck(fetchAck),
    .oFetchReq(fetchReq[1]), .oFetchAddr(fetchAddr[1]), .oPC(pcOut[1]),
    .oInstrValid(instrValid[1]), .oFlush(flush[1]), .oMisalign(misalign[1]),
    .oRedirCnt(redirCnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC, cycles of startup idle left, flush cycles left
  logic [31:0] cResetPc [2];
  int          cFlushN  [2];
  logic [31:0] mPc      [2];
  bit          mIdle    [2];
  int          mFlushLeft [2];
  bit          mValid   [2];
  bit          mMis     [2];
  int          mCnt     [2];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelStep(input int k);
    if (!rst) begin
      mIdle[k] = 1'b1;
      mFlushLeft[k] = 0;
      mPc[k] = cResetPc[k];
      mValid[k] = 1'b0;
      mMis[k] = 1'b0;
      mCnt[k] = 0;
    end else begin
      mValid[k] = 1'b0;
      if (mIdle[k]) begin
        mIdle[k] = 1'b0;
      end else if (transf && targetPC[1:0] == 2'b00) begin
        mPc[k] = targetPC;
        mFlushLeft[k] = cFlushN[k];
        if (mCnt[k] < 65535) mCnt[k]++;
      end else begin
        if (transf) mMis[k] = 1'b1;
        if (mFlushLeft[k] > 0) begin
          mFlushLeft[k]--;
        end else if (!stall && fetchAck) begin
          mPc[k] = mPc[k] + 32'd4;
          mValid[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic compareAll(input int k);
    string p;
    p = (k == 0) ? "d0" : "d1";
    checkVal({p, ".pc"},        pcOut[k],       mPc[k]);
    checkVal({p, ".fetchAddr"}, fetchAddr[k],   mPc[k]);
    checkVal({p, ".fetchReq"},  32'(fetchReq[k]), 32'(!mIdle[k] && mFlushLeft[k] == 0));
    checkVal({p, ".flush"},     32'(flush[k]),    32'(mFlushLeft[k] > 0));
    checkVal({p, ".instrValid"},32'(instrValid[k]), 32'(mValid[k]));
    checkVal({p, ".misalign"},  32'(misalign[k]), 32'(mMis[k]));
    checkVal({p, ".redirCnt"},  32'(redirCnt[k]), 32'(mCnt[k]));
  endtask

  task automatic step(input logic r, input logic t, input logic [31:0] tg,
                      input logic s, input logic a);
    rst = r; transf = t; targetPC = tg; stall = s; fetchAck = a;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    compareAll(0);
    compareAll(1);
  endtask

  initial begin
    logic [31:0] tg;
    cResetPc[0] = 32'h0040_0000; cFlushN[0] = 2;
    cResetPc[1] = 32'hFFFF_FFFC; cFlushN[1] = 3;
    rst = 1'b0; transf = 1'b0; targetPC = '0; stall = 1'b0; fetchAck = 1'b0;

    // Reset, then sequential fetch with ack every cycle (instance 1 wraps to 0)
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    // Redirect with simultaneous ack, then back-to-back redirect in first flush cycle
    step(1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0040_0200, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    // Misaligned target, then stall with ack held for three cycles
    step(1'b1, 1'b1, 32'h0040_0102, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    // Reset asserted in the middle of a flush
    step(1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tg = $urandom;
      if ($urandom_range(3, 0) != 0) tg[1:0] = 2'b00;
      step(($urandom_range(59, 0) != 0),
           ($urandom_range(5, 0) == 0),
           tg,
           ($urandom_range(3, 0) == 0),
           ($urandom_range(3, 0) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
